isa_io_cycle_engine: RTL and testbench

//  Parametrised successor to the HPS-to-ISA latch interface. Accepts one IO read/write command at a time from the HPS side.

---
 rtl/isa_pkg.sv | 24 ++
 rtl/isa_sync2.sv | 26 ++
 rtl/isa_io_cycle_engine.sv | 167 ++++++++++++++++
 tb/tb_isa_io_cycle_engine.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/isa_pkg.sv
// Shared definitions for the ISA IO cycle engine: FSM state encoding and bus constants.
package isa_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SETUP  = 3'd1,
        ST_STROBE = 3'd2,
        ST_WAIT   = 3'd3,
        ST_HOLD   = 3'd4
    } state_t;

    // Value an undriven (pulled-up) ISA data bus reads back as.
    localparam logic [31:0] ISA_FLOAT_VALUE = '1;

    function automatic int max_of4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/isa_sync2.sv
// Two-flop synchronizer for asynchronous single-bit ISA inputs (IOCHRDY, IOCHK, IRQ).
module isa_sync2 #(
    parameter logic RESET_VALUE = 1'b1
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_d,
    output logic o_q
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_meta <= RESET_VALUE;
            r_sync <= RESET_VALUE;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;

endmodule

// File: rtl/isa_io_cycle_engine.sv
// Runs one timed ISA IO read/write cycle per HPS command: setup, strobe, IOCHRDY wait, hold.
// Handshake: a command is taken on any clk edge with req_valid && req_ready; rsp_valid is a one-cycle pulse.
module isa_io_cycle_engine
    import isa_pkg::*;
#(
    parameter int DATA_WIDTH    = 16,
    parameter int ADDR_WIDTH    = 16,
    parameter int SETUP_CYCLES  = 2,
    parameter int STROBE_CYCLES = 6,
    parameter int HOLD_CYCLES   = 2,
    parameter int READY_TIMEOUT = 256
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_write,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_data,
    output logic                  rsp_valid,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  rsp_timeout,
    output logic [ADDR_WIDTH-1:0] bus_addr,
    output logic [DATA_WIDTH-1:0] bus_data_out,
    output logic                  bus_data_oe,
    input  logic [DATA_WIDTH-1:0] bus_data_in,
    output logic                  bus_iow_n,
    output logic                  bus_ior_n,
    input  logic                  bus_chrdy,
    output logic [2:0]            dbg_state
);

    localparam int CNT_MAX = max_of4(SETUP_CYCLES, STROBE_CYCLES, HOLD_CYCLES, READY_TIMEOUT);
    localparam int CNT_W   = $clog2(CNT_MAX) + 1;

    state_t                r_state;
    state_t                w_next;
    logic [CNT_W-1:0]      r_cnt;
    logic [CNT_W-1:0]      r_wait;
    logic                  r_write;
    logic                  r_abort;
    logic                  r_rsp_valid;
    logic                  r_rsp_timeout;
    logic [DATA_WIDTH-1:0] r_rsp_data;
    logic [ADDR_WIDTH-1:0] r_bus_addr;
    logic [DATA_WIDTH-1:0] r_bus_data_out;
    logic                  r_bus_data_oe;
    logic                  r_iow_n;
    logic                  r_ior_n;

    logic w_chrdy_s;
    logic w_cnt_done;
    logic w_wait_done;
    logic w_accept;
    logic w_strobe_start;
    logic w_strobe_end;
    logic w_timeout_now;
    logic w_cycle_done;

    isa_sync2 #(.RESET_VALUE(1'b1)) u_chrdy_sync (
        .i_clk   (clk),
        .i_reset (reset),
        .i_d     (bus_chrdy),
        .o_q     (w_chrdy_s)
    );

    assign w_cnt_done  = (r_cnt == '0);
    assign w_wait_done = (r_wait >= CNT_W'(READY_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (req_valid) w_next = ST_SETUP;
            ST_SETUP:  if (w_cnt_done) w_next = ST_STROBE;
            ST_STROBE: if (w_cnt_done) w_next = w_chrdy_s ? ST_HOLD : ST_WAIT;
            ST_WAIT:   if (w_chrdy_s || w_wait_done) w_next = ST_HOLD;
            ST_HOLD:   if (w_cnt_done) w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    assign w_accept       = (r_state == ST_IDLE) && req_valid;
    assign w_strobe_start = (r_state == ST_SETUP) && (w_next == ST_STROBE);
    assign w_strobe_end   = ((r_state == ST_STROBE) || (r_state == ST_WAIT)) && (w_next == ST_HOLD);
    // A ready seen on the final wait cycle wins over the timeout.
    assign w_timeout_now  = (r_state == ST_WAIT) && !w_chrdy_s && w_wait_done;
    assign w_cycle_done   = (r_state == ST_HOLD) && (w_next == ST_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt          <= '0;
            r_wait         <= '0;
            r_write        <= 1'b0;
            r_abort        <= 1'b0;
            r_rsp_valid    <= 1'b0;
            r_rsp_timeout  <= 1'b0;
            r_rsp_data     <= '0;
            r_bus_addr     <= '0;
            r_bus_data_out <= '0;
            r_bus_data_oe  <= 1'b0;
            r_iow_n        <= 1'b1;
            r_ior_n        <= 1'b1;
        end else begin
            r_rsp_valid   <= 1'b0;
            r_rsp_timeout <= 1'b0;

            // Shared down-counter reloads on every state change and parks at zero.
            if (w_next != r_state) begin
                case (w_next)
                    ST_SETUP:  r_cnt <= CNT_W'(SETUP_CYCLES - 1);
                    ST_STROBE: r_cnt <= CNT_W'(STROBE_CYCLES - 1);
                    ST_HOLD:   r_cnt <= CNT_W'(HOLD_CYCLES - 1);
                    default:   r_cnt <= '0;
                endcase
            end else if (!w_cnt_done) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (r_state != ST_WAIT) r_wait <= '0;
            else if (!w_wait_done)  r_wait <= r_wait + 1'b1;

            if (w_accept) begin
                r_bus_addr     <= req_addr;
                r_bus_data_out <= req_data;
                r_write        <= req_write;
                r_bus_data_oe  <= req_write;
                r_abort        <= 1'b0;
            end

            if (w_strobe_start) begin
                r_iow_n <= !r_write;
                r_ior_n <= r_write;
            end

            if (w_strobe_end) begin
                r_iow_n <= 1'b1;
                r_ior_n <= 1'b1;
                r_abort <= w_timeout_now;
                if (!r_write)
                    r_rsp_data <= w_timeout_now ? ISA_FLOAT_VALUE[DATA_WIDTH-1:0] : bus_data_in;
            end

            if (w_cycle_done) begin
                r_rsp_valid   <= 1'b1;
                r_rsp_timeout <= r_abort;
                r_bus_data_oe <= 1'b0;
            end
        end
    end

    assign req_ready    = (r_state == ST_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_timeout  = r_rsp_timeout;
    assign rsp_data     = r_rsp_data;
    assign bus_addr     = r_bus_addr;
    assign bus_data_out = r_bus_data_out;
    assign bus_data_oe  = r_bus_data_oe;
    assign bus_iow_n    = r_iow_n;
    assign bus_ior_n    = r_ior_n;
    assign dbg_state    = r_state;

endmodule

// File: tb/tb_isa_io_cycle_engine.sv
// Directed bench for isa_io_cycle_engine: default instance plus a READY_TIMEOUT=16 instance for the abort case.
module tb_isa_io_cycle_engine;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [15:0] req_addr;
    logic [15:0] req_data;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        rsp_timeout;
    logic [15:0] bus_addr;
    logic [15:0] bus_data_out;
    logic        bus_data_oe;
    logic [15:0] bus_data_in;
    logic        bus_iow_n;
    logic        bus_ior_n;
    logic        bus_chrdy;
    logic [2:0]  dbg_state;

    logic        req_valid_b;
    logic        req_ready_b;
    logic        rsp_valid_b;
    logic [15:0] rsp_data_b;
    logic        rsp_timeout_b;
    logic [15:0] bus_addr_b;
    logic [15:0] bus_data_out_b;
    logic        bus_data_oe_b;
    logic        bus_iow_n_b;
    logic        bus_ior_n_b;
    logic        bus_chrdy_b;
    logic [2:0]  dbg_state_b;

    int n_vec;
    int n_miss;
    int low_cnt;
    logic [15:0] exp_q[$];
    logic [15:0] exp_d;

    isa_io_cycle_engine dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_timeout(rsp_timeout),
        .bus_addr(bus_addr), .bus_data_out(bus_data_out), .bus_data_oe(bus_data_oe),
        .bus_data_in(bus_data_in), .bus_iow_n(bus_iow_n), .bus_ior_n(bus_ior_n),
        .bus_chrdy(bus_chrdy), .dbg_state(dbg_state)
    );

    isa_io_cycle_engine #(.READY_TIMEOUT(16)) dut_to (
        .clk(clk), .reset(reset), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_write(req_write), .req_addr(req_addr), .req_data(req_data),
        .rsp_valid(rsp_valid_b), .rsp_data(rsp_data_b), .rsp_timeout(rsp_timeout_b),
        .bus_addr(bus_addr_b), .bus_data_out(bus_data_out_b), .bus_data_oe(bus_data_oe_b),
        .bus_data_in(bus_data_in), .bus_iow_n(bus_iow_n_b), .bus_ior_n(bus_ior_n_b),
        .bus_chrdy(bus_chrdy_b), .dbg_state(dbg_state_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_vec++;
        assert (obs === exp_v) else begin
            n_miss++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic issue(input logic wr, input logic [15:0] addr, input logic [15:0] data);
        req_write = wr;
        req_addr  = addr;
        req_data  = data;
        req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_miss = 0;
        reset = 1'b1; req_valid = 1'b0; req_valid_b = 1'b0; req_write = 1'b0;
        req_addr = '0; req_data = '0; bus_data_in = '0; bus_chrdy = 1'b1; bus_chrdy_b = 1'b1;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        // Reset values
        check("rst_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_timeout", rsp_timeout, 0);
        check("rst_rsp_data", rsp_data, 0);
        check("rst_addr", bus_addr, 0);
        check("rst_data_out", bus_data_out, 0);
        check("rst_oe", bus_data_oe, 0);
        check("rst_iow", bus_iow_n, 1);
        check("rst_ior", bus_ior_n, 1);
        check("rst_state", dbg_state, 0);

        // 1: write 0x220 <- 0xBEEF, no wait states
        issue(1'b1, 16'h0220, 16'hBEEF);
        low_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (!bus_iow_n) low_cnt++;
            check($sformatf("t1_iow_k%0d", k), bus_iow_n, (k >= 2 && k <= 7) ? 0 : 1);
            check($sformatf("t1_ior_k%0d", k), bus_ior_n, 1);
            check($sformatf("t1_oe_k%0d", k), bus_data_oe, (k <= 9) ? 1 : 0);
            check($sformatf("t1_addr_k%0d", k), bus_addr, 16'h0220);
            check($sformatf("t1_dout_k%0d", k), bus_data_out, 16'hBEEF);
            check($sformatf("t1_rv_k%0d", k), rsp_valid, (k == 10) ? 1 : 0);
            if (k == 0) check("t1_ready_busy", req_ready, 0);
            if (k == 10) check("t1_timeout", rsp_timeout, 0);
            tick();
        end
        check("t1_iow_low_cycles", low_cnt, 6);

        // 2: read 0x22A returning 0x00AA
        bus_data_in = 16'h00AA;
        exp_q.push_back(16'h00AA);
        issue(1'b0, 16'h022A, 16'h0000);
        low_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (!bus_ior_n) low_cnt++;
            check($sformatf("t2_ior_k%0d", k), bus_ior_n, (k >= 2 && k <= 7) ? 0 : 1);
            check($sformatf("t2_iow_k%0d", k), bus_iow_n, 1);
            check($sformatf("t2_oe_k%0d", k), bus_data_oe, 0);
            check($sformatf("t2_rv_k%0d", k), rsp_valid, (k == 10) ? 1 : 0);
            if (k == 0) check("t2_addr", bus_addr, 16'h022A);
            if (k == 10) begin
                exp_d = exp_q.pop_front();
                check("t2_rsp_data", rsp_data, exp_d);
                check("t2_timeout", rsp_timeout, 0);
                bus_data_in = 16'h3333;
            end
            if (k == 11) check("t2_rsp_data_held", rsp_data, 16'h00AA);
            tick();
        end
        check("t2_ior_low_cycles", low_cnt, 6);

        // 3: read with IOCHRDY low for 20 cycles from strobe start
        bus_chrdy = 1'b0;
        bus_data_in = 16'h5A5A;
        exp_q.push_back(16'h5A5A);
        issue(1'b0, 16'h02F8, 16'h0000);
        low_cnt = 0;
        for (int k = 0; k < 29; k++) begin
            if (!bus_ior_n) low_cnt++;
            check($sformatf("t3_ior_k%0d", k), bus_ior_n, (k >= 2 && k <= 24) ? 0 : 1);
            check($sformatf("t3_rv_k%0d", k), rsp_valid, (k == 27) ? 1 : 0);
            if (k == 10) check("t3_state_wait", dbg_state, 3);
            if (k == 22) bus_chrdy = 1'b1;
            if (k == 25) bus_data_in = 16'h0000;
            if (k == 27) begin
                exp_d = exp_q.pop_front();
                check("t3_rsp_data", rsp_data, exp_d);
                check("t3_timeout", rsp_timeout, 0);
            end
            tick();
        end
        check("t3_ior_low_cycles", low_cnt, 23);

        // 4: IOCHRDY stuck low on the READY_TIMEOUT=16 instance
        bus_chrdy_b = 1'b0;
        bus_data_in = 16'h1234;
        req_write = 1'b0; req_addr = 16'h02E8; req_data = 16'h0000;
        req_valid_b = 1'b1;
        tick();
        req_valid_b = 1'b0;
        low_cnt = 0;
        for (int k = 0; k < 28; k++) begin
            if (!bus_ior_n_b) low_cnt++;
            check($sformatf("t4_ior_k%0d", k), bus_ior_n_b, (k >= 2 && k <= 23) ? 0 : 1);
            check($sformatf("t4_iow_k%0d", k), bus_iow_n_b, 1);
            check($sformatf("t4_rv_k%0d", k), rsp_valid_b, (k == 26) ? 1 : 0);
            if (k == 26) begin
                check("t4_timeout", rsp_timeout_b, 1);
                check("t4_rsp_data", rsp_data_b, 16'hFFFF);
                check("t4_ready", req_ready_b, 1);
                check("t4_state", dbg_state_b, 0);
                check("t4_oe", bus_data_oe_b, 0);
                check("t4_addr", bus_addr_b, 16'h02E8);
                check("t4_dout", bus_data_out_b, 16'h0000);
            end
            if (k == 27) check("t4_timeout_clear", rsp_timeout_b, 0);
            tick();
        end
        check("t4_ior_low_cycles", low_cnt, 22);
        bus_chrdy_b = 1'b1;

        // 5: back-to-back with req_valid held high
        bus_data_in = 16'h0C3C;
        exp_q.push_back(16'h0C3C);
        req_write = 1'b1; req_addr = 16'h0300; req_data = 16'h1111;
        req_valid = 1'b1;
        tick();
        req_write = 1'b0; req_addr = 16'h0301; req_data = 16'h2222;
        for (int k = 0; k < 23; k++) begin
            check($sformatf("t5_iow_k%0d", k), bus_iow_n, (k >= 2 && k <= 7) ? 0 : 1);
            check($sformatf("t5_ior_k%0d", k), bus_ior_n, (k >= 13 && k <= 18) ? 0 : 1);
            check($sformatf("t5_no_overlap_k%0d", k), (!bus_iow_n && !bus_ior_n), 0);
            check($sformatf("t5_rv_k%0d", k), rsp_valid, (k == 10 || k == 21) ? 1 : 0);
            check($sformatf("t5_oe_k%0d", k), bus_data_oe, (k <= 9) ? 1 : 0);
            if (k == 5) begin
                check("t5_addr1", bus_addr, 16'h0300);
                check("t5_dout1", bus_data_out, 16'h1111);
            end
            if (k == 10) check("t5_ready_on_rsp", req_ready, 1);
            if (k == 11) begin
                check("t5_addr2", bus_addr, 16'h0301);
                check("t5_state2", dbg_state, 1);
                req_valid = 1'b0;
            end
            if (k == 21) begin
                exp_d = exp_q.pop_front();
                check("t5_rsp_data2", rsp_data, exp_d);
            end
            tick();
        end

        // 6: reset in the middle of a write strobe
        issue(1'b1, 16'h0378, 16'h00FF);
        for (int k = 0; k < 5; k++) begin
            check($sformatf("t6_pre_iow_k%0d", k), bus_iow_n, (k >= 2) ? 0 : 1);
            if (k == 4) reset = 1'b1;
            tick();
        end
        reset = 1'b0;
        check("t6_iow", bus_iow_n, 1);
        check("t6_ior", bus_ior_n, 1);
        check("t6_oe", bus_data_oe, 0);
        check("t6_ready", req_ready, 1);
        check("t6_rv", rsp_valid, 0);
        check("t6_state", dbg_state, 0);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t6_quiet_rv_k%0d", k), rsp_valid, 0);
            tick();
        end
        issue(1'b1, 16'h0379, 16'h0055);
        low_cnt = 0;
        for (int k = 0; k < 12; k++) begin
            if (!bus_iow_n) low_cnt++;
            check($sformatf("t6_rv_k%0d", k), rsp_valid, (k == 10) ? 1 : 0);
            if (k == 3) check("t6_dout", bus_data_out, 16'h0055);
            if (k == 10) begin
                check("t6_timeout", rsp_timeout, 0);
                check("t6_oe_drop", bus_data_oe, 0);
            end
            tick();
        end
        check("t6_iow_low_cycles", low_cnt, 6);
        check("exp_q_drained", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
